eu_intr_sequencer: RTL and testbench

Interrupt entry/return sequencer for the CPU execution unit. It samples IRQ/FIQ requests and return-from-interrupt requests at instruction boundaries. It then drives the CPSR/SPSR/SPSR_fiq/Link/IP load and select controls of the execution unit over a fixed multi-cycle sequence. It sits between the main control unit and the EU, and owns those controls only while busy is high; the control unit ORs them in otherwise.

---
 rtl/eu_intr_pkg.sv | 53 +++++
 rtl/eu_sync2.sv | 21 ++
 rtl/eu_intr_sequencer.sv | 162 ++++++++++++++++
 tb/tb_eu_intr_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/eu_intr_pkg.sv
// Shared definitions for the execution-unit interrupt sequencer: state encoding,
// CPSR/IP mux select codes, CPSR enable bit positions and the registered control bundle.
package eu_intr_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SAVE    = 3'd1,
      MASK    = 3'd2,
      VECT    = 3'd3,
      RESTORE = 3'd4,
      RETIP   = 3'd5
   } state_t;

   localparam logic [2:0] CPSR_SEL_FLAGS    = 3'd0;
   localparam logic [2:0] CPSR_SEL_RDBUF    = 3'd1;
   localparam logic [2:0] CPSR_SEL_SPSR     = 3'd2;
   localparam logic [2:0] CPSR_SEL_SPSR_FIQ = 3'd3;
   localparam logic [2:0] CPSR_SEL_CHANGE   = 3'd4;

   localparam logic [2:0] IP_SEL_IRQ_VEC  = 3'd3;
   localparam logic [2:0] IP_SEL_FIQ_VEC  = 3'd4;
   localparam logic [2:0] IP_SEL_LINK     = 3'd5;
   localparam logic [2:0] IP_SEL_LINK_FIQ = 3'd6;

   localparam int IRQ_EN_BIT = 10;
   localparam int FIQ_EN_BIT = 13;

   // Everything the sequencer drives toward the EU, registered as one bundle.
   typedef struct packed {
      logic       busy;
      logic       intr_ack;
      logic       ret_ack;
      logic       rti_err;
      logic [2:0] cpsr_sel;
      logic [2:0] cpsr_ld;
      logic       spsr_ld;
      logic       spsr_fiq_ld;
      logic       link_ld;
      logic       link_fiq_ld;
      logic       ip_ld;
      logic [2:0] ip_sel;
   } ctrl_t;

   // CPSR value written on entry: IRQ always masked, FIQ additionally masked for FIQ entry.
   function automatic logic [31:0] mask_flags(input logic [31:0] cpsr, input logic is_fiq);
      logic [31:0] v;
      v = cpsr;
      v[IRQ_EN_BIT] = 1'b0;
      if (is_fiq) v[FIQ_EN_BIT] = 1'b0;
      return v;
   endfunction

endpackage

// File: rtl/eu_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear for a level request line.
module eu_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/eu_intr_sequencer.sv
// Interrupt entry/return sequencer: takes IRQ/FIQ/RTI at instruction boundaries and
// steps the EU's CPSR/SPSR/Link/IP load controls through a fixed multi-cycle sequence.
module eu_intr_sequencer
   import eu_intr_pkg::*;
(
   input  logic        W_Clk,
   input  logic        reset,
   input  logic        irq,
   input  logic        fiq,
   input  logic        inst_boundary,
   input  logic        rti_req,
   input  logic [31:0] CPSR_in,
   output logic        busy,
   output logic        intr_ack,
   output logic        ret_ack,
   output logic        rti_err,
   output logic        in_irq,
   output logic        in_fiq,
   output logic [2:0]  CPSR_sel,
   output logic [2:0]  CPSR_ld,
   output logic [31:0] change_flags,
   output logic        SPSR_ld,
   output logic        SPSR_fiq_ld,
   output logic        SPSR_fiq_sel,
   output logic        Link_ld,
   output logic        Link_fiq_ld,
   output logic        Link_fiq_sel,
   output logic        IP_ld,
   output logic [2:0]  IP_sel
);

   // Handshake: busy high means this block owns the EU controls and the control unit
   // stalls; intr_ack/ret_ack/rti_err are single-cycle pulses with no ready side.

   logic   irq_s, fiq_s;
   logic   irq_pend, fiq_pend;
   state_t state, state_n;
   logic   kind_fiq, kind_fiq_n;
   logic   rti_err_n;
   ctrl_t  ctrl_n, ctrl_q;

   eu_sync2 u_sync_irq (.clk(W_Clk), .rst_n(reset), .d(irq), .q(irq_s));
   eu_sync2 u_sync_fiq (.clk(W_Clk), .rst_n(reset), .d(fiq), .q(fiq_s));

   // FIQ may preempt an IRQ handler; IRQ never nests and nothing preempts FIQ.
   assign fiq_pend = fiq_s & CPSR_in[FIQ_EN_BIT] & ~in_fiq;
   assign irq_pend = irq_s & CPSR_in[IRQ_EN_BIT] & ~in_irq & ~in_fiq;

   always_comb begin
      state_n    = state;
      kind_fiq_n = kind_fiq;
      rti_err_n  = 1'b0;
      case (state)
         IDLE: begin
            if (inst_boundary) begin
               if (rti_req) begin
                  if (!in_fiq && !in_irq) begin
                     rti_err_n = 1'b1;
                  end else begin
                     state_n    = RESTORE;
                     kind_fiq_n = in_fiq;
                  end
               end else if (fiq_pend) begin
                  state_n    = SAVE;
                  kind_fiq_n = 1'b1;
               end else if (irq_pend) begin
                  state_n    = SAVE;
                  kind_fiq_n = 1'b0;
               end
            end
         end
         SAVE:    state_n = MASK;
         MASK:    state_n = VECT;
         VECT:    state_n = IDLE;
         RESTORE: state_n = RETIP;
         RETIP:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Controls are decoded from the next state so they come out of flops in the state's cycle.
   always_comb begin
      ctrl_n          = '0;
      ctrl_n.busy     = (state_n != IDLE);
      ctrl_n.rti_err  = rti_err_n;
      ctrl_n.cpsr_sel = CPSR_SEL_FLAGS;
      case (state_n)
         SAVE: begin
            ctrl_n.spsr_ld     = ~kind_fiq_n;
            ctrl_n.link_ld     = ~kind_fiq_n;
            ctrl_n.spsr_fiq_ld = kind_fiq_n;
            ctrl_n.link_fiq_ld = kind_fiq_n;
         end
         MASK: begin
            ctrl_n.cpsr_sel = CPSR_SEL_CHANGE;
            ctrl_n.cpsr_ld  = 3'b111;
         end
         VECT: begin
            ctrl_n.ip_ld    = 1'b1;
            ctrl_n.ip_sel   = kind_fiq_n ? IP_SEL_FIQ_VEC : IP_SEL_IRQ_VEC;
            ctrl_n.intr_ack = 1'b1;
         end
         RESTORE: begin
            ctrl_n.cpsr_sel = kind_fiq_n ? CPSR_SEL_SPSR_FIQ : CPSR_SEL_SPSR;
            ctrl_n.cpsr_ld  = 3'b111;
         end
         RETIP: begin
            ctrl_n.ip_ld   = 1'b1;
            ctrl_n.ip_sel  = kind_fiq_n ? IP_SEL_LINK_FIQ : IP_SEL_LINK;
            ctrl_n.ret_ack = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge W_Clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         kind_fiq <= 1'b0;
         ctrl_q   <= '0;
      end else begin
         state    <= state_n;
         kind_fiq <= kind_fiq_n;
         ctrl_q   <= ctrl_n;
      end
   end

   // Handler flags change as the final cycle of a sequence retires.
   always_ff @(posedge W_Clk or negedge reset) begin
      if (!reset) begin
         in_irq <= 1'b0;
         in_fiq <= 1'b0;
      end else begin
         if (state == VECT) begin
            if (kind_fiq) in_fiq <= 1'b1;
            else          in_irq <= 1'b1;
         end
         if (state == RETIP) begin
            if (kind_fiq) in_fiq <= 1'b0;
            else          in_irq <= 1'b0;
         end
      end
   end

   assign busy         = ctrl_q.busy;
   assign intr_ack     = ctrl_q.intr_ack;
   assign ret_ack      = ctrl_q.ret_ack;
   assign rti_err      = ctrl_q.rti_err;
   assign CPSR_sel     = ctrl_q.cpsr_sel;
   assign CPSR_ld      = ctrl_q.cpsr_ld;
   assign SPSR_ld      = ctrl_q.spsr_ld;
   assign SPSR_fiq_ld  = ctrl_q.spsr_fiq_ld;
   assign Link_ld      = ctrl_q.link_ld;
   assign Link_fiq_ld  = ctrl_q.link_fiq_ld;
   assign IP_ld        = ctrl_q.ip_ld;
   assign IP_sel       = ctrl_q.ip_sel;
   assign SPSR_fiq_sel = 1'b0;
   assign Link_fiq_sel = 1'b0;

   assign change_flags = (state == MASK) ? mask_flags(CPSR_in, kind_fiq) : 32'd0;

endmodule

// File: tb/tb_eu_intr_sequencer.sv
// Bench for eu_intr_sequencer: directed and random boundary/request traffic checked
// against a transaction-level model that queues the expected per-cycle control pattern.
module tb_eu_intr_sequencer;

   logic        W_Clk = 1'b0;
   logic        reset = 1'b1;
   logic        irq = 1'b0, fiq = 1'b0, inst_boundary = 1'b0, rti_req = 1'b0;
   logic [31:0] CPSR_in = 32'd0;
   logic        busy, intr_ack, ret_ack, rti_err, in_irq, in_fiq;
   logic [2:0]  CPSR_sel, CPSR_ld, IP_sel;
   logic [31:0] change_flags;
   logic        SPSR_ld, SPSR_fiq_ld, SPSR_fiq_sel, Link_ld, Link_fiq_ld, Link_fiq_sel, IP_ld;

   eu_intr_sequencer dut (
      .W_Clk(W_Clk), .reset(reset), .irq(irq), .fiq(fiq), .inst_boundary(inst_boundary),
      .rti_req(rti_req), .CPSR_in(CPSR_in), .busy(busy), .intr_ack(intr_ack),
      .ret_ack(ret_ack), .rti_err(rti_err), .in_irq(in_irq), .in_fiq(in_fiq),
      .CPSR_sel(CPSR_sel), .CPSR_ld(CPSR_ld), .change_flags(change_flags),
      .SPSR_ld(SPSR_ld), .SPSR_fiq_ld(SPSR_fiq_ld), .SPSR_fiq_sel(SPSR_fiq_sel),
      .Link_ld(Link_ld), .Link_fiq_ld(Link_fiq_ld), .Link_fiq_sel(Link_fiq_sel),
      .IP_ld(IP_ld), .IP_sel(IP_sel)
   );

   // ---------------- clock/reset ----------------
   always #5 W_Clk = ~W_Clk;

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic       busy, intr_ack, ret_ack, rti_err;
      logic [2:0] cpsr_sel, cpsr_ld;
      logic       spsr_ld, spsr_fiq_ld, link_ld, link_fiq_ld, ip_ld;
      logic [2:0] ip_sel;
      logic       mask, mask_fiq, set_irq, set_fiq, clr_irq, clr_fiq;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   logic [EXP_W-1:0] exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   logic m_in_irq = 1'b0, m_in_fiq = 1'b0;
   logic irq_d1 = 1'b0, irq_d2 = 1'b0, fiq_d1 = 1'b0, fiq_d2 = 1'b0;
   logic cur_mask = 1'b0, cur_mask_fiq = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] obs_ctrl();
      return {44'd0, busy, intr_ack, ret_ack, rti_err, CPSR_sel, CPSR_ld, SPSR_ld, SPSR_fiq_ld,
              Link_ld, Link_fiq_ld, IP_ld, IP_sel, SPSR_fiq_sel, Link_fiq_sel};
   endfunction

   function automatic logic [63:0] exp_ctrl(input exp_t e);
      return {44'd0, e.busy, e.intr_ack, e.ret_ack, e.rti_err, e.cpsr_sel, e.cpsr_ld, e.spsr_ld,
              e.spsr_fiq_ld, e.link_ld, e.link_fiq_ld, e.ip_ld, e.ip_sel, 2'b00};
   endfunction

   // Entry: save cycle, mask cycle, vector cycle (ack), then the handler flag is set.
   task automatic push_entry(input logic k);
      exp_t e;
      e = '0; e.busy = 1'b1;
      e.spsr_ld = ~k; e.link_ld = ~k; e.spsr_fiq_ld = k; e.link_fiq_ld = k;
      exp_q.push_back(e);
      e = '0; e.busy = 1'b1; e.cpsr_sel = 3'd4; e.cpsr_ld = 3'b111; e.mask = 1'b1; e.mask_fiq = k;
      exp_q.push_back(e);
      e = '0; e.busy = 1'b1; e.ip_ld = 1'b1; e.ip_sel = k ? 3'd4 : 3'd3; e.intr_ack = 1'b1;
      e.set_fiq = k; e.set_irq = ~k;
      exp_q.push_back(e);
   endtask

   // Return: restore CPSR from the matching SPSR, then reload IP from the matching link (ack).
   task automatic push_return(input logic k);
      exp_t e;
      e = '0; e.busy = 1'b1; e.cpsr_sel = k ? 3'd3 : 3'd2; e.cpsr_ld = 3'b111;
      exp_q.push_back(e);
      e = '0; e.busy = 1'b1; e.ip_ld = 1'b1; e.ip_sel = k ? 3'd6 : 3'd5; e.ret_ack = 1'b1;
      e.clr_fiq = k; e.clr_irq = ~k;
      exp_q.push_back(e);
   endtask

   // ---------------- driver ----------------
   // One clock: check this cycle's outputs, drive new inputs, let the model decide.
   task automatic step(input logic i_irq, input logic i_fiq, input logic i_ib,
                       input logic i_rti, input logic [31:0] i_cpsr);
      exp_t e;
      logic [31:0] cf;
      @(posedge W_Clk); #1;
      e = '0;
      if (exp_q.size() > 0) e = exp_t'(exp_q.pop_front());
      cf = 32'd0;
      if (e.mask) cf = CPSR_in & ~(32'h0000_0400 | (e.mask_fiq ? 32'h0000_2000 : 32'd0));
      check("ctrl", obs_ctrl(), exp_ctrl(e));
      check("flags", {62'd0, in_irq, in_fiq}, {62'd0, m_in_irq, m_in_fiq});
      check("change_flags", {32'd0, change_flags}, {32'd0, cf});
      if (e.set_irq) m_in_irq = 1'b1;
      if (e.set_fiq) m_in_fiq = 1'b1;
      if (e.clr_irq) m_in_irq = 1'b0;
      if (e.clr_fiq) m_in_fiq = 1'b0;
      cur_mask = e.mask; cur_mask_fiq = e.mask_fiq;

      irq = i_irq; fiq = i_fiq; inst_boundary = i_ib; rti_req = i_rti; CPSR_in = i_cpsr;
      // Requests seen by the sequencer are the levels driven two cycles ago.
      if (!e.busy && i_ib) begin
         if (i_rti) begin
            if (!m_in_irq && !m_in_fiq) begin
               e = '0; e.rti_err = 1'b1;
               exp_q.push_back(e);
            end else begin
               push_return(m_in_fiq);
            end
         end else if (fiq_d2 && i_cpsr[13] && !m_in_fiq) begin
            push_entry(1'b1);
         end else if (irq_d2 && i_cpsr[10] && !m_in_irq && !m_in_fiq) begin
            push_entry(1'b0);
         end
      end
      irq_d2 = irq_d1; irq_d1 = i_irq;
      fiq_d2 = fiq_d1; fiq_d1 = i_fiq;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, obs_ctrl(), 64'd0);
      check({tag, "_flags"}, {62'd0, in_irq, in_fiq}, 64'd0);
      check({tag, "_change_flags"}, {32'd0, change_flags}, 64'd0);
   endtask

   task automatic apply_reset_and_release();
      irq = 1'b0; fiq = 1'b0; inst_boundary = 1'b0; rti_req = 1'b0; CPSR_in = 32'd0;
      repeat (2) @(posedge W_Clk);
      @(negedge W_Clk);
      exp_q.delete();
      m_in_irq = 1'b0; m_in_fiq = 1'b0;
      irq_d1 = 1'b0; irq_d2 = 1'b0; fiq_d1 = 1'b0; fiq_d2 = 1'b0;
      reset = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic        r_irq, r_fiq, found;
      logic [31:0] r_cpsr;

      #1 reset = 1'b0;
      #1 check_all_zero("reset");
      apply_reset_and_release();

      // IRQ entry, then FIQ preempting the IRQ handler.
      repeat (8) step(1, 0, 1, 0, 32'h0000_2400);
      repeat (8) step(1, 1, 1, 0, 32'h0000_2000);
      // Nested return: FIQ first, then IRQ (requests masked by CPSR_in=0).
      step(1, 1, 1, 1, 32'h0);
      repeat (3) step(1, 1, 1, 0, 32'h0);
      step(1, 1, 1, 1, 32'h0);
      repeat (3) step(1, 1, 0, 0, 32'h0);
      // rti with nothing active, and an unmasked irq with no boundary.
      step(0, 0, 1, 1, 32'h0000_2400);
      repeat (6) step(1, 0, 0, 0, 32'h0000_2400);
      // Both pending: FIQ wins; rti and pending FIQ together: return wins.
      repeat (6) step(1, 1, 1, 0, 32'h0000_2400);
      step(1, 1, 1, 1, 32'h0000_2400);
      repeat (6) step(0, 0, 1, 0, 32'h0);

      // Randomized traffic.
      r_irq = 1'b0; r_fiq = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) r_irq = ~r_irq;
         if ($urandom_range(0, 9) == 0) r_fiq = ~r_fiq;
         r_cpsr = $urandom;
         r_cpsr[10] = ($urandom_range(0, 3) != 0);
         r_cpsr[13] = ($urandom_range(0, 3) != 0);
         step(r_irq, r_fiq, ($urandom_range(0, 9) < 6), ($urandom_range(0, 5) == 0), r_cpsr);
      end

      // Reset in the middle of a FIQ entry that preempts an IRQ handler.
      step(0, 0, 1, 1, 32'h0);
      step(0, 0, 1, 1, 32'h0);
      repeat (4) step(0, 0, 1, 0, 32'h0);
      repeat (8) step(1, 0, 1, 0, 32'h0000_2400);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1, 1, 1, 0, 32'h0000_2000);
         if (cur_mask && cur_mask_fiq) found = 1'b1;
      end
      check("reach_fiq_mask", {63'd0, found}, 64'd1);
      #1 reset = 1'b0;
      #1 check_all_zero("mid_reset");
      apply_reset_and_release();
      repeat (4) step(0, 0, 1, 0, 32'h0000_2400);

      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 5) == 0) r_irq = ~r_irq;
         if ($urandom_range(0, 7) == 0) r_fiq = ~r_fiq;
         step(r_irq, r_fiq, ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
              {18'd0, $urandom_range(0, 1) == 1, 2'b00, $urandom_range(0, 1) == 1, 10'd0});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
